// File: rtl/alarm_disp_scan.sv
// alarm_disp_scan
//   Drives an 8-digit multiplexed common-anode 7-segment display for the
//   watch/alarm core. Digits 7..4 show the current time HH.MM and digits 3..0
//   show the alarm time HH.MM. The BCD inputs are snapshotted once per frame
//   so that a single scan frame never mixes old and new time values.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot (>=2)
//   BLINK_DIV  clk cycles per blink half-period (>=2)
//
// Ports
//   clk                      system clock
//   rst                      synchronous active-high reset
//   hourdec_now..minone_now  current time, BCD
//   hourdec_bud..minone_bud  alarm time, BCD
//   aud_en                   alarm sounding, enables blinking of the alarm digits
//   seg[6:0]                 segments {g,f,e,d,c,b,a}, active-low, registered
//   dp                       decimal point, active-low, registered
//   an[7:0]                  digit anodes, active-low, an[7] leftmost, registered
//
// Build option
//   LEADING_ZERO_BLANK_EN    when defined, a zero tens-of-hours digit (now or
//                            alarm) is shown with all segments off.

module alarm_disp_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic [3:0] hourdec_bud,
  input  logic [3:0] hourone_bud,
  input  logic [3:0] mindec_bud,
  input  logic [3:0] minone_bud,
  input  logic       aud_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;
  logic               snap_pending;
  logic               scan_tick;

  logic [3:0] snap_hourdec_now, snap_hourone_now, snap_mindec_now, snap_minone_now;
  logic [3:0] snap_hourdec_bud, snap_hourone_bud, snap_mindec_bud, snap_minone_bud;

  logic [3:0] cur_digit;
  logic [6:0] seg_next;
  logic       dp_next;
  logic [7:0] an_next;

  // BCD to active-low segment pattern; non-decimal codes show a dash
  function automatic logic [6:0] decode_bcd(input logic [3:0] bcd);
    case (bcd)
      4'd0:    decode_bcd = 7'h40;
      4'd1:    decode_bcd = 7'h79;
      4'd2:    decode_bcd = 7'h24;
      4'd3:    decode_bcd = 7'h30;
      4'd4:    decode_bcd = 7'h19;
      4'd5:    decode_bcd = 7'h12;
      4'd6:    decode_bcd = 7'h02;
      4'd7:    decode_bcd = 7'h78;
      4'd8:    decode_bcd = 7'h00;
      4'd9:    decode_bcd = 7'h10;
      default: decode_bcd = 7'h3F;
    endcase
  endfunction

  assign scan_tick = (scan_cnt == SCAN_LAST);

  // Slot timer and digit pointer: each slot lasts SCAN_DIV cycles, and the
  // pointer advances on the last cycle of a slot, wrapping 7 back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
    end else begin
      if (scan_tick) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Free-running blink phase shared by the colon and the alarm-digit blink.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Input snapshot: taken once right after reset release so the first frame
  // has real data, then at every frame boundary (pointer wrapping 7 -> 0).
  // The display logic reads only these copies, keeping each frame coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_pending     <= 1'b1;
      snap_hourdec_now <= 4'd0;
      snap_hourone_now <= 4'd0;
      snap_mindec_now  <= 4'd0;
      snap_minone_now  <= 4'd0;
      snap_hourdec_bud <= 4'd0;
      snap_hourone_bud <= 4'd0;
      snap_mindec_bud  <= 4'd0;
      snap_minone_bud  <= 4'd0;
    end else if (snap_pending || (scan_tick && digit_idx == 3'd7)) begin
      snap_pending     <= 1'b0;
      snap_hourdec_now <= hourdec_now;
      snap_hourone_now <= hourone_now;
      snap_mindec_now  <= mindec_now;
      snap_minone_now  <= minone_now;
      snap_hourdec_bud <= hourdec_bud;
      snap_hourone_bud <= hourone_bud;
      snap_mindec_bud  <= mindec_bud;
      snap_minone_bud  <= minone_bud;
    end
  end

  // Next display values for the slot the pointer currently selects. The
  // alarm-digit blank overrides everything for slots 3..0 but leaves the
  // slot timing alone.
  always_comb begin
    cur_digit = 4'd0;
    case (digit_idx)
      3'd7: cur_digit = snap_hourdec_now;
      3'd6: cur_digit = snap_hourone_now;
      3'd5: cur_digit = snap_mindec_now;
      3'd4: cur_digit = snap_minone_now;
      3'd3: cur_digit = snap_hourdec_bud;
      3'd2: cur_digit = snap_hourone_bud;
      3'd1: cur_digit = snap_mindec_bud;
      default: cur_digit = snap_minone_bud;
    endcase

    seg_next = decode_bcd(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if ((digit_idx == 3'd7 || digit_idx == 3'd3) && cur_digit == 4'd0) begin
      seg_next = 7'h7F;
    end
`else
    seg_next = seg_next;
`endif

    dp_next = 1'b1;
    if ((digit_idx == 3'd6 && blink_ph) || digit_idx == 3'd2) begin
      dp_next = 1'b0;
    end

    an_next = ~(8'b1 << digit_idx);

    if (aud_en && blink_ph && !digit_idx[2]) begin
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      an_next  = 8'hFF;
    end
  end

  // Registered display outputs, dark during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 8'hFF;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_alarm_disp_scan.sv
// tb_alarm_disp_scan
//   Scoreboard bench for alarm_disp_scan with SCAN_DIV=4, BLINK_DIV=16.
//   Before each clock edge the expected display outputs for that edge are
//   pushed to a queue; after the edge they are popped and compared.

module tb_alarm_disp_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;
  localparam int FRAME     = 8 * SCAN_DIV;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
  logic       aud_en;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;

  int compared   = 0;
  int mismatched = 0;
  int k          = 0;
  logic [3:0] model_snap [8];
  exp_t exp_q [$];

  alarm_disp_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .hourdec_bud(hourdec_bud), .hourone_bud(hourone_bud),
    .mindec_bud(mindec_bud), .minone_bud(minone_bud),
    .aud_en(aud_en), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_decode(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h3F;
    return tbl[d];
  endfunction

  // Expected outputs after edge number kk (counted from reset release):
  // they show the slot selected before that edge, the blink phase before it,
  // and aud_en as sampled at it.
  function automatic exp_t model_out(input int kk, input logic aud);
    exp_t e;
    int idx;
    logic ph;
    logic [3:0] d;
    idx = (kk / SCAN_DIV) % 8;
    ph  = ((kk / BLINK_DIV) % 2) == 1;
    d   = model_snap[idx];
    e.seg = ref_decode(d);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx == 7 || idx == 3) && d == 4'd0) e.seg = 7'h7F;
`endif
    e.dp = !((idx == 6 && ph) || idx == 2);
    e.an = 8'hFF;
    e.an[idx] = 1'b0;
    if (aud && ph && idx < 4) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.an  = 8'hFF;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s k=%0d observed=%02h expected=%02h", tag, k, observed, expected);
    end
  endtask

  // One clock: push expectation, let the edge happen, pop and compare.
  task automatic applyStimulus(input int cycles);
    exp_t e, got;
    for (int c = 0; c < cycles; c++) begin
      if (rst) begin
        e.seg = 7'h7F; e.dp = 1'b1; e.an = 8'hFF;
      end else begin
        e = model_out(k, aud_en);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (rst) begin
        k = 0;
        for (int i = 0; i < 8; i++) model_snap[i] = 4'd0;
      end else begin
        if (k == 0 || (k % FRAME) == FRAME - 1) begin
          model_snap[7] = hourdec_now; model_snap[6] = hourone_now;
          model_snap[5] = mindec_now;  model_snap[4] = minone_now;
          model_snap[3] = hourdec_bud; model_snap[2] = hourone_bud;
          model_snap[1] = mindec_bud;  model_snap[0] = minone_bud;
        end
        k++;
      end
      if (exp_q.size() == 0) begin
        checkOutput("queue_empty", 8'd0, 8'd1);
      end else begin
        got = exp_q.pop_front();
        checkOutput("seg", {1'b0, seg}, {1'b0, got.seg});
        checkOutput("dp", {7'd0, dp}, {7'd0, got.dp});
        checkOutput("an", an, got.an);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_snap[i] = 4'd0;
    rst = 1'b1;
    aud_en = 1'b0;
    hourdec_now = 4'd1; hourone_now = 4'd2; mindec_now = 4'd3; minone_now = 4'd4;
    hourdec_bud = 4'd0; hourone_bud = 4'd7; mindec_bud = 4'd0; minone_bud = 4'd5;
    #2;
    $display("[TB] reset phase");
    applyStimulus(3);
    rst = 1'b0;

    $display("[TB] 12:34 / 07:05 scan, two frames");
    applyStimulus(2 * FRAME);

    $display("[TB] time change in the middle of a frame");
    while ((k % FRAME) != 3 * SCAN_DIV) applyStimulus(1);
    minone_now = 4'd5;
    applyStimulus(2 * FRAME);

    $display("[TB] non-decimal hour ones digit");
    hourone_now = 4'hB;
    applyStimulus(2 * FRAME);
    hourone_now = 4'd2;

    $display("[TB] alarm sounding blink");
    aud_en = 1'b1;
    applyStimulus(3 * FRAME);
    aud_en = 1'b0;
    applyStimulus(FRAME / 2);

    $display("[TB] reset in the middle of a frame");
    while ((k % FRAME) != 5 * SCAN_DIV + 1) applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    hourdec_bud = 4'd2;
    applyStimulus(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
